// File: rtl/ccd_cds_readout_if.sv
// Pixel stream from the CDS readout stage to the frame packer (valid/ready, FWFT head).
interface ccd_cds_readout_if #(
    parameter int unsigned ADC_W = 12
);
    logic [ADC_W-1:0] pix_data;
    logic             pix_first;
    logic             pix_last;
    logic             pix_valid;
    logic             pix_ready;

    modport master (
        output pix_data,
        output pix_first,
        output pix_last,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_first,
        input  pix_last,
        input  pix_valid,
        output pix_ready
    );
endinterface

// File: rtl/ccd_cds_readout.sv
// Correlated-double-sampling readout: samples reset/signal levels off the CCD phases and queues reset-signal pixels.
// Optional feature: define CCD_CDS_SATURATE_EN to clamp negative differences to 0 instead of wrapping.
module ccd_cds_readout #(
    parameter int unsigned ADC_W        = 12,
    parameter int unsigned PIX_PER_LINE = 64,
    parameter int unsigned SETTLE       = 2,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              phi_p,
    input  logic              phi_r,
    input  logic              phi_l2,
    input  logic [ADC_W-1:0]  adc_data,
    ccd_cds_readout_if.master pix,
    output logic              overflow,
    output logic              line_err
);

    localparam int unsigned CNT_W = $clog2(PIX_PER_LINE + 1);
    localparam int unsigned SET_W = 4;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_R   = 3'd1;
    localparam logic [2:0] S_SETTLE_R = 3'd2;
    localparam logic [2:0] S_WAIT_S   = 3'd3;
    localparam logic [2:0] S_SETTLE_S = 3'd4;

    typedef struct packed {
        logic             first;
        logic             last;
        logic [ADC_W-1:0] data;
    } pix_t;

    // Phase synchronisers, bit order {phi_p, phi_r, phi_l2}
    logic [2:0] ph_q1, ph_q2;
    logic       rise_p_c, fall_r_c, fall_l2_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q1 <= '0;
            ph_q2 <= '0;
        end else begin
            ph_q1 <= {phi_p, phi_r, phi_l2};
            ph_q2 <= ph_q1;
        end
    end

    assign rise_p_c  =  ph_q1[2] & ~ph_q2[2];
    assign fall_r_c  = ~ph_q1[1] &  ph_q2[1];
    assign fall_l2_c = ~ph_q1[0] &  ph_q2[0];

    logic [2:0]       state_q, state_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;
    logic [ADC_W-1:0] r_lvl_q, r_lvl_d;
    logic             push_c, err_set_c, line_done_c;
    logic [ADC_W-1:0] cds_c;

`ifdef CCD_CDS_SATURATE_EN
    assign cds_c = (adc_data > r_lvl_q) ? '0 : (r_lvl_q - adc_data);
`else
    assign cds_c = r_lvl_q - adc_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Sampling sequencer; a phi_p rise outside IDLE restarts the line after any same-cycle push
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        r_lvl_d     = r_lvl_q;
        push_c      = 1'b0;
        err_set_c   = 1'b0;
        line_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rise_p_c) begin
                    cnt_d   = '0;
                    first_d = 1'b1;
                    state_d = S_WAIT_R;
                end
            end
            S_WAIT_R: begin
                if (fall_r_c) begin
                    settle_d = SET_W'(SETTLE);
                    state_d  = S_SETTLE_R;
                end
            end
            S_SETTLE_R: begin
                if (settle_q == '0) begin
                    r_lvl_d = adc_data;
                    state_d = S_WAIT_S;
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            S_WAIT_S: begin
                if (fall_l2_c) begin
                    settle_d = SET_W'(SETTLE);
                    state_d  = S_SETTLE_S;
                end
            end
            S_SETTLE_S: begin
                if (settle_q == '0) begin
                    push_c  = 1'b1;
                    first_d = 1'b0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(PIX_PER_LINE - 1)) begin
                        line_done_c = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_WAIT_R;
                    end
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rise_p_c && (state_q != S_IDLE)) begin
            err_set_c = ~line_done_c;
            cnt_d     = '0;
            first_d   = 1'b1;
            state_d   = S_WAIT_R;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q <= '0;
            cnt_q    <= '0;
            first_q  <= 1'b0;
            r_lvl_q  <= '0;
        end else begin
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            r_lvl_q  <= r_lvl_d;
        end
    end

    // FWFT pixel FIFO; a push on a full FIFO is accepted only if the head pops in the same cycle
    pix_t             mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count_q, count_d;
    logic             valid_q;
    logic             full_c, pop_c, wr_en_c;
    pix_t             wr_pix_c, head_c;

    assign full_c   = (count_q == CW'(FIFO_DEPTH));
    assign pop_c    = valid_q & pix.pix_ready;
    assign wr_en_c  = push_c & (~full_c | pop_c);
    assign wr_pix_c = '{first: first_q,
                        last:  (cnt_q == CNT_W'(PIX_PER_LINE - 1)),
                        data:  cds_c};
    assign head_c   = mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (wr_en_c && !pop_c)      count_d = count_q + CW'(1);
        else if (!wr_en_c && pop_c) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            overflow <= 1'b0;
            line_err <= 1'b0;
        end else begin
            if (wr_en_c) begin
                mem[wr_ptr] <= wr_pix_c;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
            if (push_c && full_c && !pop_c) overflow <= 1'b1;
            if (err_set_c)                  line_err <= 1'b1;
        end
    end

    assign pix.pix_data  = head_c.data;
    assign pix.pix_first = head_c.first;
    assign pix.pix_last  = head_c.last;
    assign pix.pix_valid = valid_q;

endmodule
